param_update_scheduler: RTL and testbench

Host-to-model parameter scheduler that sits between the OpalKelly wire/trigger endpoints and the neuron, synapse and muscle parameter inputs (tau, ltp, ltd, p_delta, clk_divider, …). It queues 32-bit parameter writes from the host in a small FIFO. It commits them to a register bank only on a simulation-step boundary (`sim_tick`), so every model block sees a coherent parameter set for a whole 1 ms step. It replaces the per-register asynchronous trigger latches with one clocked, ordered update path.

---
 rtl/param_sched_pkg.sv | 35 +++
 rtl/param_sched_fifo.sv | 51 +++++
 rtl/param_update_scheduler.sv | 109 ++++++++++
 tb/tb_param_update_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_sched_pkg.sv
// rtl/param_sched_pkg.sv - shared types and reset defaults for the parameter update scheduler
package param_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

  typedef enum int {
    TAU     = 0,
    LTP     = 1,
    LTD     = 2,
    P_DELTA = 3,
    CLK_DIV = 4
  } param_idx_e;

  localparam int MAX_NREG = 8;

  localparam logic [31:0] RESET_DEFAULTS [MAX_NREG] = '{
    32'h3cf5c28f, 32'h0, 32'h0, 32'h0,
    32'h0,        32'h0, 32'h0, 32'h0
  };

  // Registers beyond the table default to zero.
  function automatic logic [31:0] reset_default(input int idx);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < MAX_NREG; i++) begin
      if (i == idx) v = RESET_DEFAULTS[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/param_sched_fifo.sv
// rtl/param_sched_fifo.sv - synchronous FIFO of {addr, data} parameter writes
module param_sched_fifo #(
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     push_i,
  input  logic [AW-1:0]            push_addr_i,
  input  logic [31:0]              push_data_i,
  input  logic                     pop_i,
  output logic [AW-1:0]            pop_addr_o,
  output logic [31:0]              pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW+31:0] mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           push_ok, pop_ok;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = count_q;
  assign {pop_addr_o, pop_data_o} = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/param_update_scheduler.sv
// rtl/param_update_scheduler.sv - queues host parameter writes and commits them as a batch on sim_tick
module param_update_scheduler
  import param_sched_pkg::*;
#(
  parameter int NREG  = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_strobe,
  input  logic [AW-1:0]            wr_addr,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  input  logic                     sim_tick,
  input  logic                     hold,
  output logic [NREG*32-1:0]       regs_out,
  output logic                     update_done,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  sched_state_e  state_q, state_d;
  logic [CW-1:0] batch_q, batch_d;
  logic          update_done_q;
  logic          overflow_q;
  logic          pop;

  logic [AW-1:0] fifo_addr;
  logic [31:0]   fifo_data;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  param_sched_fifo #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .push_i      (wr_strobe),
    .push_addr_i (wr_addr),
    .push_data_i (wr_data),
    .pop_i       (pop),
    .pop_addr_o  (fifo_addr),
    .pop_data_o  (fifo_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      batch_q       <= '0;
      update_done_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      batch_q       <= batch_d;
      update_done_q <= (state_d == DONE);
      overflow_q    <= overflow_q | (wr_strobe & fifo_full);
    end
  end

  // The batch size is frozen at the tick, so later pushes wait for the next step.
  always_comb begin
    state_d = state_q;
    batch_d = batch_q;
    case (state_q)
      IDLE: begin
        if (sim_tick && !hold && !fifo_empty) begin
          state_d = APPLY;
          batch_d = fifo_count;
        end
      end
      APPLY: begin
        batch_d = batch_q - CW'(1);
        if (batch_q <= CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop = (state_q == APPLY) && !fifo_empty;
  end

  // Out-of-range addresses match no register and are simply dropped on pop.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [31:0] reg_q;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        reg_q <= reset_default(gi);
      end else if (pop && (fifo_addr == AW'(gi))) begin
        reg_q <= fifo_data;
      end
    end
    assign regs_out[32*gi +: 32] = reg_q;
  end

  assign wr_ready    = !fifo_full;
  assign update_done = update_done_q;
  assign pending     = fifo_count;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_param_update_scheduler.sv
// tb/tb_param_update_scheduler.sv - randomized self-checking bench for param_update_scheduler
module tb_param_update_scheduler;

  localparam int NREG  = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              wr_strobe;
  logic [AW-1:0]     wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;
  logic              sim_tick;
  logic              hold;
  logic [NREG*32-1:0] regs_out;
  logic              update_done;
  logic [CW-1:0]     pending;
  logic              overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]    m_regs [NREG];
  logic [AW+31:0] m_q [$];
  logic           m_ovf;

  always #5 clk = ~clk;

  param_update_scheduler #(
    .NREG  (NREG),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_strobe   (wr_strobe),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .sim_tick    (sim_tick),
    .hold        (hold),
    .regs_out    (regs_out),
    .update_done (update_done),
    .pending     (pending),
    .overflow    (overflow)
  );

  function automatic logic [NREG*32-1:0] m_flat();
    logic [NREG*32-1:0] f;
    for (int i = 0; i < NREG; i++) f[32*i +: 32] = m_regs[i];
    return f;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = (i == 0) ? 32'h3cf5c28f : 32'h0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic m_apply(input logic [AW+31:0] e);
    for (int i = 0; i < NREG; i++) begin
      if (i == int'(e[AW+31:32])) m_regs[i] = e[31:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cycle(input logic [AW-1:0] a, input logic [31:0] d);
    wr_strobe = 1'b1;
    wr_addr   = a;
    wr_data   = d;
    step();
    wr_strobe = 1'b0;
    if (m_q.size() < DEPTH) m_q.push_back({a, d});
    else m_ovf = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    int seen;
    apply_reset();
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL reset_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL reset_pending got %0d exp 0", pending); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL reset_update_done got %b exp 0", update_done); end
    seen = 0;
    repeat (10) begin
      sim_tick = 1'b1;
      step();
      sim_tick = 1'b0;
      if (update_done) seen++;
      step();
      if (update_done) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL idle_ticks_done got %0d exp 0", seen); end
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL idle_ticks_regs got %h exp %h", regs_out, m_flat()); end
  endtask

  task automatic test_basic();
    write_cycle(3'd1, 32'h00000010);
    write_cycle(3'd2, 32'h00000020);
    n_checks++; if (pending !== 3'd2) begin n_fail++; $display("FAIL basic_pending got %0d exp 2", pending); end
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL basic_t1_regs got %h exp %h", regs_out, m_flat()); end
    step();
    m_apply(m_q.pop_front());
    n_checks++; if (regs_out[63:32] !== 32'h10) begin n_fail++; $display("FAIL basic_t2_reg1 got %h exp 10", regs_out[63:32]); end
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL basic_t2_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL basic_t2_done got %b exp 0", update_done); end
    step();
    m_apply(m_q.pop_front());
    n_checks++; if (regs_out[95:64] !== 32'h20) begin n_fail++; $display("FAIL basic_t3_reg2 got %h exp 20", regs_out[95:64]); end
    n_checks++; if (update_done !== 1'b1) begin n_fail++; $display("FAIL basic_t3_done got %b exp 1", update_done); end
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL basic_t3_pending got %0d exp 0", pending); end
    step();
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL basic_t4_done got %b exp 0", update_done); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) write_cycle(3'($urandom_range(0, NREG-1)), $urandom);
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_full_ready got %b exp 0", wr_ready); end
    n_checks++; if (pending !== 3'(DEPTH)) begin n_fail++; $display("FAIL ovf_full_pending got %0d exp %0d", pending, DEPTH); end
    write_cycle(3'd5, 32'hdeadbeef);
    n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL ovf_flag got %b exp %b", overflow, m_ovf); end
    n_checks++; if (pending !== 3'(m_q.size())) begin n_fail++; $display("FAIL ovf_pending got %0d exp %0d", pending, m_q.size()); end
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_t1 got %b exp 0", wr_ready); end
    step();
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_t2 got %b exp 1", wr_ready); end
    repeat (DEPTH) step();
    while (m_q.size() > 0) m_apply(m_q.pop_front());
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL ovf_batch_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky1 got %b exp 1", overflow); end
    write_cycle(3'd0, $urandom);
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    repeat (2) step();
    m_apply(m_q.pop_front());
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL ovf_batch2_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky2 got %b exp 1", overflow); end
  endtask

  task automatic test_hold();
    logic [31:0] a = $urandom;
    logic [31:0] b = $urandom;
    int seen;
    write_cycle(3'd3, a);
    write_cycle(3'd3, b);
    hold = 1'b1;
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    seen = 0;
    repeat (5) begin if (update_done) seen++; step(); end
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL hold_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (pending !== 3'd2) begin n_fail++; $display("FAIL hold_pending got %0d exp 2", pending); end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL hold_done got %0d exp 0", seen); end
    hold = 1'b0;
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    seen = 0;
    repeat (4) begin if (update_done) seen++; step(); end
    while (m_q.size() > 0) m_apply(m_q.pop_front());
    n_checks++; if (regs_out[127:96] !== b) begin n_fail++; $display("FAIL hold_later_wins got %h exp %h", regs_out[127:96], b); end
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL hold_release_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (seen != 1) begin n_fail++; $display("FAIL hold_release_done got %0d exp 1", seen); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] z = $urandom;
    write_cycle(3'd7, $urandom);
    write_cycle(3'd6, $urandom);
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    wr_strobe = 1'b1;
    wr_addr   = 3'd0;
    wr_data   = z;
    step();
    wr_strobe = 1'b0;
    sim_tick  = 1'b1;
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL oor_t2_regs got %h exp %h", regs_out, m_flat()); end
    step();
    n_checks++; if (update_done !== 1'b1) begin n_fail++; $display("FAIL oor_done got %b exp 1", update_done); end
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL oor_done_regs got %h exp %h", regs_out, m_flat()); end
    step();
    sim_tick = 1'b0;
    while (m_q.size() > 0) m_apply(m_q.pop_front());
    m_q.push_back({3'd0, z});
    n_checks++; if (pending !== 3'd1) begin n_fail++; $display("FAIL apply_push_pending got %0d exp 1", pending); end
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL apply_push_idle_done got %b exp 0", update_done); end
    repeat (3) step();
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL apply_push_deferred got %h exp %h", regs_out, m_flat()); end
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    step();
    m_apply(m_q.pop_front());
    n_checks++; if (regs_out[31:0] !== z) begin n_fail++; $display("FAIL apply_push_next_tick got %h exp %h", regs_out[31:0], z); end
    n_checks++; if (update_done !== 1'b1) begin n_fail++; $display("FAIL apply_push_done got %b exp 1", update_done); end
    step();
  endtask

  task automatic test_reset_mid_apply();
    int seen;
    logic [31:0] d = $urandom;
    write_cycle(3'd1, $urandom | 32'h1);
    write_cycle(3'd2, $urandom | 32'h1);
    write_cycle(3'd3, $urandom | 32'h1);
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    step();
    m_apply(m_q.pop_front());
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL midrst_partial got %h exp %h", regs_out, m_flat()); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m_reset();
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL midrst_regs got %h exp %h", regs_out, m_flat()); end
    n_checks++; if (pending !== 3'd0) begin n_fail++; $display("FAIL midrst_pending got %0d exp 0", pending); end
    n_checks++; if (update_done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", update_done); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midrst_overflow got %b exp 0", overflow); end
    seen = 0;
    repeat (6) begin if (update_done) seen++; step(); end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL midrst_no_done got %0d exp 0", seen); end
    write_cycle(3'd4, d);
    sim_tick = 1'b1;
    step();
    sim_tick = 1'b0;
    step();
    m_apply(m_q.pop_front());
    n_checks++; if (update_done !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_done got %b exp 1", update_done); end
    n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL midrst_idle_regs got %h exp %h", regs_out, m_flat()); end
    step();
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      int nw;
      int n;
      int qsz;
      int popped;
      nw = $urandom_range(0, DEPTH + 1);
      for (int w = 0; w < nw; w++) write_cycle(3'($urandom_range(0, 7)), $urandom);
      hold = ($urandom_range(0, 3) == 0);
      qsz  = m_q.size();
      n    = hold ? 0 : qsz;
      sim_tick = 1'b1;
      step();
      sim_tick = 1'b0;
      for (int c = 1; c <= n + 2; c++) begin
        if (c >= 2 && c - 2 < n) m_apply(m_q.pop_front());
        popped = (c - 1 < n) ? c - 1 : n;
        n_checks++; if (regs_out !== m_flat()) begin n_fail++; $display("FAIL rnd%0d_c%0d_regs got %h exp %h", r, c, regs_out, m_flat()); end
        n_checks++; if (update_done !== (n > 0 && c == n + 1)) begin n_fail++; $display("FAIL rnd%0d_c%0d_done got %b exp %b", r, c, update_done, (n > 0 && c == n + 1)); end
        n_checks++; if (pending !== 3'(qsz - popped)) begin n_fail++; $display("FAIL rnd%0d_c%0d_pending got %0d exp %0d", r, c, pending, qsz - popped); end
        n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd%0d_c%0d_overflow got %b exp %b", r, c, overflow, m_ovf); end
        step();
      end
      hold = 1'b0;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    wr_strobe = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    sim_tick  = 1'b0;
    hold      = 1'b0;
    m_reset();
    test_reset();
    test_basic();
    test_overflow();
    apply_reset();
    test_hold();
    test_out_of_range();
    test_reset_mid_apply();
    apply_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
